// File: rtl/maple_rx_controller.sv
// Maple bus receive frame sequencer: start/end pattern detection, byte forwarding,
// length and XOR checksum checking. Ports: line edge strobes in, decoder byte in, rx stream and status out.
`timescale 1ns/1ps
module maple_rx_controller #(
  parameter int TW = 16,
  parameter logic [TW-1:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sdcka_data,
  input  logic       sdcka_posedge,
  input  logic       sdcka_negedge,
  input  logic       sdckb_data,
  input  logic       sdckb_posedge,
  input  logic       sdckb_negedge,
  input  logic [7:0] dec_data,
  input  logic       dec_ready,
  output logic       dec_enable,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_first,
  output logic [10:0] byte_count,
  output logic       frame_done,
  output logic       frame_ok,
  output logic       err_checksum,
  output logic       err_length,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_RECEIVE, S_END, S_CHECK
  } state_t;

  localparam logic [TW-1:0] TLAST = TIMEOUT - TW'(1);

  state_t        state, next_state;
  logic [2:0]    pulse_cnt;
  logic [7:0]    chk;
  logic [7:0]    len_words;
  logic          exp_b;
  logic [TW-1:0] tmr;

  logic          any_edge;
  logic          active;
  logic          tmo;
  logic          take_byte;
  logic          start_go;
  logic          end_hit;
  logic          len_bad;
  logic [10:0]   exp_len;

  // SDCKA level is implied by its edge strobes here.
  logic unused_lvl;
  assign unused_lvl = sdcka_data;

  assign any_edge = sdcka_posedge | sdcka_negedge
                  | sdckb_posedge | sdckb_negedge;
  assign active = (state == S_START) || (state == S_RECEIVE)
               || (state == S_END);
  assign tmo = active && !any_edge && (tmr == TLAST);
  // Simultaneous A/B falls count as A then B: never an end pattern.
  assign end_hit = sdcka_negedge && !sdckb_negedge && exp_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (sdcka_negedge && sdckb_data) next_state = S_START;
      end
      S_START: begin
        if (tmo) next_state = S_IDLE;
        else if (sdcka_posedge)
          next_state = (pulse_cnt == 3'd4) ? S_RECEIVE : S_IDLE;
      end
      S_RECEIVE: begin
        if (tmo)          next_state = S_IDLE;
        else if (end_hit) next_state = S_END;
      end
      S_END: begin
        if (tmo)                next_state = S_IDLE;
        else if (sdckb_posedge) next_state = S_CHECK;
      end
      S_CHECK: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    take_byte = dec_ready
             && ((state == S_RECEIVE) || (state == S_END));
    start_go  = (state == S_IDLE) && (next_state == S_START);
    exp_len   = 11'd5 + {1'b0, len_words, 2'b00};
    len_bad   = (byte_count < 11'd4) || (byte_count != exp_len);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_enable   <= 1'b0;
      rx_byte      <= 8'd0;
      rx_valid     <= 1'b0;
      rx_first     <= 1'b0;
      byte_count   <= 11'd0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      err_checksum <= 1'b0;
      err_length   <= 1'b0;
      err_timeout  <= 1'b0;
      pulse_cnt    <= 3'd0;
      chk          <= 8'd0;
      len_words    <= 8'd0;
      exp_b        <= 1'b0;
      tmr          <= '0;
    end else begin
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      frame_done <= 1'b0;
      dec_enable <= (next_state == S_RECEIVE);

      if (!active || any_edge) tmr <= '0;
      else                     tmr <= tmr + TW'(1);

      if (start_go) begin
        pulse_cnt    <= 3'd0;
        byte_count   <= 11'd0;
        chk          <= 8'd0;
        len_words    <= 8'd0;
        frame_ok     <= 1'b0;
        err_checksum <= 1'b0;
        err_length   <= 1'b0;
        err_timeout  <= 1'b0;
      end

      if (state == S_START && sdckb_negedge && pulse_cnt != 3'd7)
        pulse_cnt <= pulse_cnt + 3'd1;

      if (state == S_START) exp_b <= 1'b0;
      else if (state == S_RECEIVE) begin
        if (sdckb_negedge)      exp_b <= 1'b0;
        else if (sdcka_negedge) exp_b <= 1'b1;
      end

      if (take_byte) begin
        rx_byte  <= dec_data;
        rx_valid <= 1'b1;
        rx_first <= (byte_count == 11'd0);
        chk      <= chk ^ dec_data;
        if (byte_count != 11'h7FF) byte_count <= byte_count + 11'd1;
        if (byte_count == 11'd3)   len_words  <= dec_data;
      end

      if (state == S_CHECK) begin
        frame_done   <= 1'b1;
        err_checksum <= (chk != 8'd0);
        err_length   <= len_bad;
        frame_ok     <= (chk == 8'd0) && !len_bad;
        err_timeout  <= 1'b0;
      end

      if (tmo) begin
        frame_done   <= 1'b1;
        err_timeout  <= 1'b1;
        frame_ok     <= 1'b0;
        err_checksum <= 1'b0;
        err_length   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maple_rx_controller.sv
// Bench for maple_rx_controller: table frames, corner sequences,
// random frames against a byte-list reference model.
`timescale 1ns/1ps
module tb_maple_rx_controller;

  localparam logic [15:0] TMO = 16'd200;

  logic       clk = 1'b0;
  logic       reset;
  logic       sdcka_data, sdcka_posedge, sdcka_negedge;
  logic       sdckb_data, sdckb_posedge, sdckb_negedge;
  logic [7:0] dec_data;
  logic       dec_ready;
  logic       dec_enable;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_first;
  logic [10:0] byte_count;
  logic       frame_done, frame_ok;
  logic       err_checksum, err_length, err_timeout;

  maple_rx_controller #(.TW(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .sdcka_data(sdcka_data), .sdcka_posedge(sdcka_posedge),
    .sdcka_negedge(sdcka_negedge),
    .sdckb_data(sdckb_data), .sdckb_posedge(sdckb_posedge),
    .sdckb_negedge(sdckb_negedge),
    .dec_data(dec_data), .dec_ready(dec_ready),
    .dec_enable(dec_enable), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .rx_first(rx_first),
    .byte_count(byte_count), .frame_done(frame_done),
    .frame_ok(frame_ok), .err_checksum(err_checksum),
    .err_length(err_length), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name,
                       input logic [31:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: sole writer of the observation records.
  logic [7:0] got[$];
  int         first_cnt = 0;
  logic [7:0] first_byte = 8'd0;
  int         done_cnt = 0;
  int         en_cnt = 0;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (rx_valid) begin
        got.push_back(rx_byte);
        if (rx_first) begin
          first_cnt++;
          first_byte = rx_byte;
        end
      end
      if (frame_done) done_cnt++;
      if (dec_enable) en_cnt++;
    end
  end

  logic [7:0] fq[$];

  task automatic step(input logic an, ap, bn, bp, dr,
                      input logic [7:0] dd);
    sdcka_negedge = an; sdcka_posedge = ap;
    sdckb_negedge = bn; sdckb_posedge = bp;
    dec_ready = dr; dec_data = dd;
    if (an) sdcka_data = 1'b0;
    if (ap) sdcka_data = 1'b1;
    @(posedge clk); #1;
    sdcka_negedge = 0; sdcka_posedge = 0;
    sdckb_negedge = 0; sdckb_posedge = 0;
    dec_ready = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 8'd0);
  endtask

  task automatic start_seq(input int pulses);
    step(1, 0, 0, 0, 0, 8'd0);
    for (int i = 0; i < pulses; i++) begin
      step(0, 0, 1, 0, 0, 8'd0);
      step(0, 0, 0, 1, 0, 8'd0);
    end
    step(0, 1, 0, 0, 0, 8'd0);
  endtask

  task automatic bits(input bit simul);
    for (int j = 0; j < 2; j++) begin
      if (simul && $urandom_range(0, 3) == 0)
        step(1, 0, 1, 0, 0, 8'd0);
      else begin
        step(1, 0, 0, 0, 0, 8'd0);
        if (simul && $urandom_range(0, 3) == 0) idle(1);
        step(0, 0, 1, 0, 0, 8'd0);
      end
    end
  endtask

  // Reference: frame status straight from the byte list.
  task automatic ref_model(output logic ok, ck, ln,
                           output logic [10:0] cnt);
    int n;
    logic [7:0] x;
    n = fq.size();
    x = 8'd0;
    foreach (fq[k]) x ^= fq[k];
    cnt = 11'(n);
    ck = (x != 8'd0);
    if (n < 4) ln = 1'b1;
    else       ln = (n != 5 + 4 * int'(fq[3]));
    ok = !ck && !ln;
  endtask

  // last_mode: 0 = all bytes mid-frame, 1 = last byte with the
  // end-pattern edge, 2 = last byte while waiting in END.
  task automatic run_frame(input int last_mode, input bit simul,
                           input logic eok, eck, eln,
                           input logic [10:0] ecnt,
                           input string tag);
    int base, f0, d0, n, lm, nm;
    base = got.size(); f0 = first_cnt; d0 = done_cnt;
    n = fq.size();
    lm = (n == 0) ? 0 : last_mode;
    step(1, 0, 0, 0, 0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0, 8'd0);
      step(0, 0, 0, 1, 0, 8'd0);
    end
    check({tag, "_en_pre"}, 32'(dec_enable), 0);
    step(0, 1, 0, 0, 0, 8'd0);
    check({tag, "_en_rise"}, 32'(dec_enable), 1);
    for (int k = 0; k < n; k++) begin
      if (k == n - 1 && lm != 0) break;
      bits(simul);
      step(0, 0, 0, 0, 1, fq[k]);
    end
    bits(simul);
    step(1, 0, 0, 0, 0, 8'd0);
    step(0, 1, 0, 0, 0, 8'd0);
    step(1, 0, 0, 0, lm == 1, (n > 0) ? fq[n-1] : 8'd0);
    check({tag, "_en_fall"}, 32'(dec_enable), 0);
    if (lm == 2) step(0, 0, 0, 0, 1, fq[n-1]);
    step(0, 0, 0, 1, 0, 8'd0);
    check({tag, "_done_early"}, 32'(frame_done), 0);
    @(posedge clk); #1;
    check({tag, "_done"}, 32'(frame_done), 1);
    check({tag, "_status"},
          {frame_ok, err_checksum, err_length, err_timeout},
          {eok, eck, eln, 1'b0});
    check({tag, "_count"}, 32'(byte_count), 32'(ecnt));
    @(posedge clk); #1;
    check({tag, "_held"},
          {frame_done, frame_ok, err_checksum, err_length},
          {1'b0, eok, eck, eln});
    check({tag, "_count_held"}, 32'(byte_count), 32'(ecnt));
    check({tag, "_ndone"}, done_cnt - d0, 1);
    check({tag, "_nvalid"}, got.size() - base, n);
    nm = 0;
    if (got.size() - base == n)
      for (int k = 0; k < n; k++)
        if (got[base+k] == fq[k]) nm++;
    check({tag, "_bytes"}, nm, n);
    check({tag, "_nfirst"}, first_cnt - f0, (n > 0) ? 1 : 0);
    if (n > 0) check({tag, "_first"}, 32'(first_byte), 32'(fq[0]));
    idle(2);
  endtask

  typedef struct packed {
    logic [3:0]  n;
    logic [71:0] d;
    logic        ok;
    logic        ck;
    logic        ln;
    logic [10:0] cnt;
  } vec_t;

  vec_t vec[6];

  initial begin
    int d0, e0, n, cyc;
    logic mok, mck, mln;
    logic [10:0] mcnt;
    int pulses_tab[3];

    vec[0] = '{4'd9, {8'h20, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
                      8'h01, 8'h00, 8'h20, 8'h01},
               1'b1, 1'b0, 1'b0, 11'd9};
    vec[1] = '{4'd9, {8'hA0, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
                      8'h01, 8'h00, 8'h20, 8'h01},
               1'b0, 1'b1, 1'b0, 11'd9};
    vec[2] = '{4'd9, {8'h23, 8'hDD, 8'hCC, 8'hBB, 8'hAA,
                      8'h02, 8'h00, 8'h20, 8'h01},
               1'b0, 1'b0, 1'b1, 11'd9};
    vec[3] = '{4'd5, {32'h0, 8'h21, 8'h00, 8'h00, 8'h20, 8'h01},
               1'b1, 1'b0, 1'b0, 11'd5};
    vec[4] = '{4'd2, {56'h0, 8'h11, 8'h11},
               1'b0, 1'b0, 1'b1, 11'd2};
    vec[5] = '{4'd0, 72'h0, 1'b0, 1'b0, 1'b1, 11'd0};

    sdcka_data = 1; sdcka_posedge = 0; sdcka_negedge = 0;
    sdckb_data = 1; sdckb_posedge = 0; sdckb_negedge = 0;
    dec_data = 0; dec_ready = 0;
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          {dec_enable, rx_byte, rx_valid, rx_first, byte_count,
           frame_done, frame_ok, err_checksum, err_length,
           err_timeout}, 0);
    @(negedge clk); reset = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      fq.delete();
      for (int k = 0; k < int'(vec[i].n); k++)
        fq.push_back(vec[i].d[8*k +: 8]);
      run_frame(i % 3, 1'b0, vec[i].ok, vec[i].ck, vec[i].ln,
                vec[i].cnt, $sformatf("vec%0d", i));
    end

    // Wrong pulse counts, including one that a wrapping counter accepts.
    pulses_tab[0] = 3; pulses_tab[1] = 5; pulses_tab[2] = 12;
    for (int p = 0; p < 3; p++) begin
      d0 = done_cnt; e0 = en_cnt;
      start_seq(pulses_tab[p]);
      idle(int'(TMO) + 10);
      check($sformatf("badstart%0d_en", pulses_tab[p]),
            en_cnt - e0, 0);
      check($sformatf("badstart%0d_done", pulses_tab[p]),
            done_cnt - d0, 0);
    end

    // Start edge ignored while SDCKB is low.
    d0 = done_cnt; e0 = en_cnt;
    sdckb_data = 0;
    start_seq(4);
    sdckb_data = 1;
    idle(int'(TMO) + 10);
    check("nostart_en", en_cnt - e0, 0);
    check("nostart_done", done_cnt - d0, 0);

    // Timeout after two bytes.
    d0 = done_cnt;
    start_seq(4);
    bits(1'b0); step(0, 0, 0, 0, 1, 8'h5A);
    bits(1'b0); step(0, 0, 0, 0, 1, 8'hC3);
    step(0, 0, 1, 0, 0, 8'd0);
    n = 0;
    cyc = 0;
    while (cyc < int'(TMO) + 20) begin
      @(posedge clk); #1;
      cyc++;
      if (frame_done) begin
        n = cyc;
        break;
      end
    end
    check("timeout_latency", n, 32'(TMO));
    check("timeout_status",
          {frame_ok, err_checksum, err_length, err_timeout,
           dec_enable}, 5'b00010);
    check("timeout_count", 32'(byte_count), 2);
    idle(3);
    check("timeout_ndone", done_cnt - d0, 1);

    // Reset asserted during the third byte.
    d0 = done_cnt;
    start_seq(4);
    bits(1'b0); step(0, 0, 0, 0, 1, 8'h01);
    bits(1'b0); step(0, 0, 0, 0, 1, 8'h20);
    step(1, 0, 0, 0, 0, 8'd0);
    check("pre_reset_count", 32'(byte_count), 2);
    #2 reset = 0;
    #1;
    check("midreset_outputs",
          {dec_enable, rx_byte, rx_valid, rx_first, byte_count,
           frame_done, frame_ok, err_checksum, err_length,
           err_timeout}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    idle(3);
    check("midreset_ndone", done_cnt - d0, 0);
    fq.delete();
    for (int k = 0; k < 9; k++) fq.push_back(vec[0].d[8*k +: 8]);
    run_frame(0, 1'b0, 1'b1, 1'b0, 1'b0, 11'd9, "post_reset");

    // Random frames against the reference model.
    for (int r = 0; r < 30; r++) begin
      int mode, lw, idx;
      logic [7:0] x;
      fq.delete();
      mode = $urandom_range(0, 2);
      if (mode < 2) begin
        lw = $urandom_range(0, 2);
        for (int k = 0; k < 3; k++) fq.push_back(8'($urandom));
        fq.push_back(8'(lw));
        for (int k = 0; k < 4 * lw; k++)
          fq.push_back(8'($urandom));
        x = 8'd0;
        foreach (fq[k]) x ^= fq[k];
        fq.push_back(x);
        if (mode == 1) begin
          idx = $urandom_range(0, fq.size() - 1);
          fq[idx] = fq[idx] ^ 8'($urandom_range(1, 255));
        end
      end else begin
        n = $urandom_range(0, 12);
        for (int k = 0; k < n; k++) fq.push_back(8'($urandom));
      end
      ref_model(mok, mck, mln, mcnt);
      run_frame($urandom_range(0, 2), 1'b1, mok, mck, mln, mcnt,
                $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
